// File: rtl/wb_regfile.sv
// Write-back stage register file: selects write-back data, commits it into a
// 32-entry register file, serves two read ports and counts committed writes.
// Optional debug read port and last-written index enabled by WB_REGFILE_DBG_EN.
module wb_regfile #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 32,
    parameter int BYPASS = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              WB_MemtoReg,
    input  logic              WB_RegWrite,
    input  logic [DATA_W-1:0] WB_rdata,
    input  logic [DATA_W-1:0] WB_ALU_res,
    input  logic [4:0]        WB_wreg,
    input  logic [4:0]        raddr1,
    input  logic [4:0]        raddr2,
    output logic [DATA_W-1:0] rdata1,
    output logic [DATA_W-1:0] rdata2,
    output logic [DATA_W-1:0] wb_wdata,
    output logic [CNT_W-1:0]  wr_count
`ifdef WB_REGFILE_DBG_EN
    ,
    input  logic [4:0]        dbg_addr,
    output logic [DATA_W-1:0] dbg_data,
    output logic [4:0]        dbg_last_wreg
`endif
);

    logic [DATA_W-1:0] r_regs [0:31];
    logic [CNT_W-1:0]  r_wr_count;
    logic              w_commit;

    assign wb_wdata = WB_MemtoReg ? WB_rdata : WB_ALU_res;
    assign w_commit = WB_RegWrite && (WB_wreg != 5'd0);
    assign wr_count = r_wr_count;

    // Entry 0 is cleared at reset and never written, so it always reads 0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < 32; i++) begin
                r_regs[i] <= '0;
            end
            r_wr_count <= '0;
        end else if (w_commit) begin
            r_regs[WB_wreg] <= wb_wdata;
            r_wr_count      <= r_wr_count + CNT_W'(1);
        end
    end

    always_comb begin
        rdata1 = r_regs[raddr1];
        if (raddr1 == 5'd0) begin
            rdata1 = '0;
        end else if ((BYPASS != 0) && WB_RegWrite && (WB_wreg == raddr1)) begin
            rdata1 = wb_wdata;
        end
    end

    always_comb begin
        rdata2 = r_regs[raddr2];
        if (raddr2 == 5'd0) begin
            rdata2 = '0;
        end else if ((BYPASS != 0) && WB_RegWrite && (WB_wreg == raddr2)) begin
            rdata2 = wb_wdata;
        end
    end

`ifdef WB_REGFILE_DBG_EN
    logic [4:0] r_last_wreg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_last_wreg <= '0;
        end else if (w_commit) begin
            r_last_wreg <= WB_wreg;
        end
    end

    assign dbg_last_wreg = r_last_wreg;
    assign dbg_data      = (dbg_addr == 5'd0) ? '0 : r_regs[dbg_addr];
`endif

endmodule

// File: tb/tb_wb_regfile.sv
// Scoreboard bench for wb_regfile: a bypassing 32-bit-counter instance and a
// non-bypassing 4-bit-counter instance share one stimulus stream.
module tb_wb_regfile;

    logic        clk;
    logic        rst;
    logic        WB_MemtoReg;
    logic        WB_RegWrite;
    logic [31:0] WB_rdata;
    logic [31:0] WB_ALU_res;
    logic [4:0]  WB_wreg;
    logic [4:0]  raddr1;
    logic [4:0]  raddr2;
    logic [31:0] a_rdata1, a_rdata2, a_wdata, a_cnt;
    logic [31:0] b_rdata1, b_rdata2, b_wdata;
    logic [3:0]  b_cnt;
`ifdef WB_REGFILE_DBG_EN
    logic [4:0]  dbg_addr;
    logic [31:0] a_dbg_data, b_dbg_data;
    logic [4:0]  a_dbg_last, b_dbg_last;
`endif

    wb_regfile #(.DATA_W(32), .CNT_W(32), .BYPASS(1)) u_byp (
        .clk(clk), .rst(rst), .WB_MemtoReg(WB_MemtoReg), .WB_RegWrite(WB_RegWrite),
        .WB_rdata(WB_rdata), .WB_ALU_res(WB_ALU_res), .WB_wreg(WB_wreg),
        .raddr1(raddr1), .raddr2(raddr2), .rdata1(a_rdata1), .rdata2(a_rdata2),
        .wb_wdata(a_wdata), .wr_count(a_cnt)
`ifdef WB_REGFILE_DBG_EN
        , .dbg_addr(dbg_addr), .dbg_data(a_dbg_data), .dbg_last_wreg(a_dbg_last)
`endif
    );

    wb_regfile #(.DATA_W(32), .CNT_W(4), .BYPASS(0)) u_nobyp (
        .clk(clk), .rst(rst), .WB_MemtoReg(WB_MemtoReg), .WB_RegWrite(WB_RegWrite),
        .WB_rdata(WB_rdata), .WB_ALU_res(WB_ALU_res), .WB_wreg(WB_wreg),
        .raddr1(raddr1), .raddr2(raddr2), .rdata1(b_rdata1), .rdata2(b_rdata2),
        .wb_wdata(b_wdata), .wr_count(b_cnt)
`ifdef WB_REGFILE_DBG_EN
        , .dbg_addr(dbg_addr), .dbg_data(b_dbg_data), .dbg_last_wreg(b_dbg_last)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        int unsigned sel;
        logic [31:0] exp;
    } exp_t;

    exp_t        sb[$];
    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    logic [31:0] m_regs [0:31];
    logic [31:0] m_cnt_a;
    logic [3:0]  m_cnt_b;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] m_wdata();
        return WB_MemtoReg ? WB_rdata : WB_ALU_res;
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] a, input bit byp);
        if (a == 5'd0) return 32'd0;
        if (byp && WB_RegWrite && (WB_wreg == a)) return m_wdata();
        return m_regs[a];
    endfunction

    task automatic m_clear();
        for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
        m_cnt_a = 32'd0;
        m_cnt_b = 4'd0;
    endtask

    task automatic push(input string tag, input int unsigned sel, input logic [31:0] exp);
        exp_t e;
        e.tag = tag;
        e.sel = sel;
        e.exp = exp;
        sb.push_back(e);
    endtask

    task automatic push_all(input string ph);
        push({ph, "_a_rd1"}, 0, m_read(raddr1, 1'b1));
        push({ph, "_a_rd2"}, 1, m_read(raddr2, 1'b1));
        push({ph, "_wdata"}, 2, m_wdata());
        push({ph, "_a_cnt"}, 3, m_cnt_a);
        push({ph, "_b_rd1"}, 4, m_read(raddr1, 1'b0));
        push({ph, "_b_rd2"}, 5, m_read(raddr2, 1'b0));
        push({ph, "_b_cnt"}, 6, {28'd0, m_cnt_b});
    endtask

    task automatic drain();
        exp_t        e;
        logic [31:0] act;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            case (e.sel)
                0: act = a_rdata1;
                1: act = a_rdata2;
                2: act = a_wdata;
                3: act = a_cnt;
                4: act = b_rdata1;
                5: act = b_rdata2;
                default: act = {28'd0, b_cnt};
            endcase
            check(e.tag, act, e.exp);
        end
    endtask

    // One clock cycle: check outputs before the edge, commit in the model,
    // then drop the write enable and check stored contents after the edge.
    task automatic cycle(input string tag, input logic we, input logic m2r,
                         input logic [4:0] wreg, input logic [31:0] ld,
                         input logic [31:0] alu, input logic [4:0] ra1,
                         input logic [4:0] ra2);
        @(negedge clk);
        WB_RegWrite = we;  WB_MemtoReg = m2r; WB_wreg = wreg;
        WB_rdata    = ld;  WB_ALU_res  = alu;
        raddr1      = ra1; raddr2      = ra2;
        #1;
        push_all({tag, "_pre"});
        drain();
        @(posedge clk);
        if (rst && we && (wreg != 5'd0)) begin
            m_regs[wreg] = m_wdata();
            m_cnt_a      = m_cnt_a + 32'd1;
            m_cnt_b      = m_cnt_b + 4'd1;
        end
        #1;
        WB_RegWrite = 1'b0;
        #1;
        push_all({tag, "_post"});
        drain();
    endtask

    initial begin
        rst = 1'b0; WB_RegWrite = 1'b0; WB_MemtoReg = 1'b0; WB_wreg = 5'd0;
        WB_rdata = '0; WB_ALU_res = '0; raddr1 = 5'd5; raddr2 = 5'd0;
`ifdef WB_REGFILE_DBG_EN
        dbg_addr = 5'd0;
`endif
        m_clear();
        #2;
        push_all("reset");
        drain();
        @(negedge clk);
        rst = 1'b1;

        cycle("mux_ld",  1'b1, 1'b1, 5'd3, 32'hDEADBEEF, 32'h11111111, 5'd3, 5'd0);
        cycle("mux_alu", 1'b1, 1'b0, 5'd3, 32'hDEADBEEF, 32'h11111111, 5'd3, 5'd3);

        cycle("byp_init", 1'b1, 1'b0, 5'd7, 32'h0, 32'hA, 5'd0, 5'd7);
        cycle("byp_wr",   1'b1, 1'b0, 5'd7, 32'h0, 32'hB, 5'd3, 5'd7);

        cycle("zero_wr",  1'b1, 1'b1, 5'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd0, 5'd0);

        cycle("r9_init",  1'b1, 1'b0, 5'd9, 32'h0, 32'h99, 5'd9, 5'd7);
        cycle("dis_wr",   1'b0, 1'b0, 5'd9, 32'h55, 32'h55, 5'd9, 5'd9);

        for (int i = 0; i < 6; i++) begin
            cycle("rand", 1'b1, 1'($urandom_range(0, 1)), 5'($urandom_range(1, 31)),
                  $urandom, $urandom, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
        end

        // Asynchronous reset in mid-cycle, with a write pending across an edge.
        cycle("r5_wr", 1'b1, 1'b0, 5'd5, 32'h0, 32'h1234, 5'd5, 5'd3);
        @(negedge clk);
        #2;
        rst = 1'b0;
        m_clear();
        #1;
        push_all("async_rst");
        drain();
        cycle("rst_pend", 1'b1, 1'b0, 5'd5, 32'h0, 32'h777, 5'd5, 5'd6);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 1; i <= 17; i++) begin
            cycle("wrap_wr", 1'b1, 1'b0, 5'(i), 32'h0, 32'h100 + 32'(i), 5'(i), 5'd0);
        end
        check("wrap_b_cnt", {28'd0, b_cnt}, 32'd1);
        check("wrap_a_cnt", a_cnt, 32'd17);
        for (int i = 1; i <= 17; i++) begin
            cycle("wrap_rd", 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 5'(i), 5'(18 - i));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/wb_regfile.md
Name: wb_regfile

Overview:
- Write-back end of the MEM/WB interface: consumes the WB-side pipeline register outputs and selects the write-back data.
- Commits that data into a 32-entry architectural register file.
- Serves two ID-stage read ports, with optional same-cycle write-through bypass.
- Keeps a count of committed register writes for performance and debug.

Parameters:
- DATA_W, 32, register and data width in bits.
- CNT_W, 32, width of the committed-write counter.
- BYPASS, 1, 1 = a read port returns the same-cycle write data on an address match; 0 = a read port returns stored contents only.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- WB_MemtoReg  input  1  1 = write memory load data; 0 = write ALU result.
- WB_RegWrite  input  1  write enable for this cycle.
- WB_rdata  input  DATA_W  load data from the MEM/WB register.
- WB_ALU_res  input  DATA_W  ALU result from the MEM/WB register.
- WB_wreg  input  5  destination register index.
- raddr1  input  5  read port 1 address.
- raddr2  input  5  read port 2 address.
- rdata1  output  DATA_W  read port 1 data, combinational.
- rdata2  output  DATA_W  read port 2 data, combinational.
- wb_wdata  output  DATA_W  selected write-back data, combinational.
- wr_count  output  CNT_W  number of committed writes.

Behaviour:
- Reset:
  - rst low asynchronously clears all 32 registers and wr_count to 0.
  - Result: rdata1 = rdata2 = 0 and wr_count = 0 while rst is low.
  - The state stays cleared until the first rising clk edge with rst high.
  - rst asserted mid-operation discards any write pending at that edge.
- Write-data select:
  - wb_wdata = WB_MemtoReg ? WB_rdata : WB_ALU_res.
  - Purely combinational; valid regardless of WB_RegWrite.
- Commit:
  - On the rising clk edge with rst high, WB_RegWrite = 1 and WB_wreg != 0: reg[WB_wreg] <= wb_wdata, and wr_count increments by 1.
  - Write latency is 1 cycle.
- Register $0:
  - Hardwired to 0 and never written.
  - A write with WB_wreg = 0 is dropped and does not increment wr_count.
- Read:
  - rdataN = 0 when raddrN = 0.
  - Otherwise, if BYPASS = 1, WB_RegWrite = 1 and WB_wreg = raddrN, then rdataN = wb_wdata (same-cycle write-through).
  - Otherwise rdataN = reg[raddrN].
  - Both ports are independent; matching addresses on both ports return identical data.
- wr_count:
  - Unsigned; wraps from 2^CNT_W - 1 to 0 with no saturation and no flag.
- X handling:
  - WB_wreg, WB_MemtoReg and the data inputs are don't-care when WB_RegWrite = 0; no state changes in that case.
- No internal state machine beyond the storage array and counter; no stall or handshake. The write is accepted unconditionally every qualifying cycle.

Optional Feature:
- Macro: WB_REGFILE_DBG_EN.
- Defined:
  - Adds input dbg_addr (5) and outputs dbg_data (DATA_W) and dbg_last_wreg (5).
  - dbg_data is a third read port with no bypass: stored value only, 0 for address 0.
  - dbg_last_wreg captures WB_wreg at every committed write and resets to 0.
- Not defined:
  - These ports and their logic do not exist.
  - All other behaviour is identical.

Test Plan:
- Reset: drive rst low mid-cycle after writing reg 5 = 0x1234 -> immediately rdata1 (raddr1 = 5) = 0 and wr_count = 0, without waiting for a clock edge.
- Mux select:
  - WB_RegWrite = 1, WB_wreg = 3, WB_MemtoReg = 1, WB_rdata = 0xDEADBEEF, WB_ALU_res = 0x11111111 -> after the edge, reg 3 reads 0xDEADBEEF.
  - Repeat with WB_MemtoReg = 0 -> reg 3 reads 0x11111111; wr_count = 2.
- Bypass:
  - BYPASS = 1, reg 7 holds 0xA; in the same cycle write reg 7 with ALU result 0xB and raddr2 = 7 -> rdata2 = 0xB before the edge.
  - With BYPASS = 0 -> rdata2 = 0xA before the edge and 0xB after it.
- Zero register: write reg 0 with 0xFFFFFFFF -> rdata1 (raddr1 = 0) = 0 both before and after the edge; wr_count unchanged.
- Disabled write: WB_RegWrite = 0, WB_wreg = 9, data = 0x55 -> reg 9 keeps its prior value and wr_count is unchanged.
- Counter wrap: CNT_W = 4, perform 17 committed writes to regs 1..17 -> wr_count = 1; all 17 registers hold their written values.
